lcd_display: RTL and testbench



---
 rtl/lcd_display_if.sv | 20 ++
 rtl/lcd_display.sv | 144 ++++++++++++++
 tb/tb_lcd_display.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_display_if.sv
// Byte-level handshake between an LCD command/character sequencer (master)
// and the HD44780 4-bit bus driver (slave).
interface lcd_display_if;
  logic [7:0]  if_data;
  logic        if_rs;
  logic [31:0] if_delay;
  logic        if_write;
  logic        if_ready;
  logic        if_8bit;

  modport master (
    output if_data, if_rs, if_delay, if_write, if_8bit,
    input  if_ready
  );

  modport slave (
    input  if_data, if_rs, if_delay, if_write, if_8bit,
    output if_ready
  );
endinterface

// File: rtl/lcd_display.sv
// HD44780 4-bit bus driver: one byte per handshake, nibble strobes with
// setup/pulse/hold/gap timing, then a caller-chosen post-command wait.
module lcd_display #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 50
) (
  input  logic         clk,
  input  logic         rst,
  lcd_display_if.slave bus,
  output logic         lcd_e,
  output logic         lcd_rw,
  output logic         lcd_rs,
  output logic [3:0]   lcd_d
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP_H,
    S_PULSE_H,
    S_HOLD_H,
    S_GAP,
    S_SETUP_L,
    S_PULSE_L,
    S_HOLD_L,
    S_WAIT
  } state_t;

  // Each state's counter is loaded with (duration - 1) and runs down to 0.
  localparam logic [31:0] C_SETUP = 32'(T_SETUP - 1);
  localparam logic [31:0] C_PULSE = 32'(T_PULSE - 1);
  localparam logic [31:0] C_HOLD  = 32'(T_HOLD - 1);
  localparam logic [31:0] C_GAP   = 32'(T_GAP - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] delay_q, delay_d;
  logic        b8_q, b8_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [3:0]  lcd_d_q, lcd_d_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      delay_q  <= '0;
      b8_q     <= 1'b0;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      delay_q  <= delay_d;
      b8_q     <= b8_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_d_q  <= lcd_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    delay_d  = delay_q;
    b8_d     = b8_q;
    lcd_rs_d = lcd_rs_q;
    lcd_d_d  = lcd_d_q;

    if (state_q == S_IDLE) begin
      if (bus.if_write) begin
        data_d   = bus.if_data;
        delay_d  = bus.if_delay;
        b8_d     = bus.if_8bit;
        lcd_rs_d = bus.if_rs;
        lcd_d_d  = bus.if_data[7:4];
        state_d  = S_SETUP_H;
        cnt_d    = C_SETUP;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end else begin
      case (state_q)
        S_SETUP_H: begin
          state_d = S_PULSE_H;
          cnt_d   = C_PULSE;
        end
        S_PULSE_H: begin
          state_d = S_HOLD_H;
          cnt_d   = C_HOLD;
        end
        S_HOLD_H: begin
          if (b8_q) begin
            state_d = S_GAP;
            cnt_d   = C_GAP;
          end else if (delay_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = delay_q - 32'd1;
          end
        end
        S_GAP: begin
          state_d = S_SETUP_L;
          cnt_d   = C_SETUP;
          lcd_d_d = data_q[3:0];
        end
        S_SETUP_L: begin
          state_d = S_PULSE_L;
          cnt_d   = C_PULSE;
        end
        S_PULSE_L: begin
          state_d = S_HOLD_L;
          cnt_d   = C_HOLD;
        end
        S_HOLD_L: begin
          if (delay_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = delay_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // E is registered so the strobe is glitch-free and only high in pulse states.
    lcd_e_d = (state_d == S_PULSE_H) || (state_d == S_PULSE_L);
  end

  assign bus.if_ready = (state_q == S_IDLE);
  assign lcd_e        = lcd_e_q;
  assign lcd_rw       = 1'b0;
  assign lcd_rs       = lcd_rs_q;
  assign lcd_d        = lcd_d_q;

endmodule

// File: tb/tb_lcd_display.sv
// Scoreboard bench for lcd_display: stimulus queues expected E pulses and
// busy lengths; a monitor reconstructs them from the LCD pins and compares.
module tb_lcd_display;
  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rw, lcd_rs;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_display_if bif();

  lcd_display dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bif.slave),
    .lcd_e  (lcd_e),
    .lcd_rw (lcd_rw),
    .lcd_rs (lcd_rs),
    .lcd_d  (lcd_d)
  );

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         rise;
  } pulse_t;

  pulse_t exp_pulse[$];
  int     exp_busy[$];
  int     tests = 0;
  int     fails = 0;
  logic   rw_seen = 1'b0;

  localparam int BOUND = 30000;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample per cycle on the falling edge.
  initial begin : monitor
    logic       e_prev;
    int         busy_cnt, width, rise_idx, stable;
    logic [3:0] nib_r, d_prev;
    logic       rs_r, rs_prev, setup_ok, d_moved;
    pulse_t     ep;
    e_prev = 1'b0; busy_cnt = 0; width = 0; rise_idx = 0; stable = 0;
    nib_r = '0; d_prev = '0; rs_r = 1'b0; rs_prev = 1'b0;
    setup_ok = 1'b0; d_moved = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_rw) rw_seen = 1'b1;
      if (rst) begin
        e_prev = 1'b0; busy_cnt = 0; width = 0; stable = 0;
      end else begin
        if (!bif.if_ready) begin
          busy_cnt++;
        end else if (busy_cnt > 0) begin
          if (exp_busy.size() == 0) check("busy_unexpected", busy_cnt, 0);
          else check("busy_len", busy_cnt, exp_busy.pop_front());
          busy_cnt = 0;
        end
        if (lcd_d == d_prev && lcd_rs == rs_prev) stable++;
        else stable = 1;
        if (lcd_e && !e_prev) begin
          width    = 1;
          rise_idx = busy_cnt;
          nib_r    = lcd_d;
          rs_r     = lcd_rs;
          setup_ok = (stable >= 3);
          d_moved  = 1'b0;
        end else if (lcd_e) begin
          width++;
          if (lcd_d != nib_r || lcd_rs != rs_r) d_moved = 1'b1;
        end else if (e_prev) begin
          if (exp_pulse.size() == 0) begin
            check("pulse_unexpected", 1, 0);
          end else begin
            ep = exp_pulse.pop_front();
            check("pulse_nibble", nib_r, ep.nib);
            check("pulse_rs", rs_r, ep.rs);
            check("pulse_rise_cycle", rise_idx, ep.rise);
            check("pulse_width", width, 12);
            check("pulse_setup", setup_ok, 1);
            check("pulse_hold", (!d_moved && lcd_d == nib_r && lcd_rs == rs_r), 1);
          end
        end
        d_prev = lcd_d;
        rs_prev = lcd_rs;
        e_prev = lcd_e;
      end
    end
  end

  task automatic wait_ready(input logic level);
    int n = 0;
    while (bif.if_ready !== level && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic expect_xfer(input logic [7:0] d, input logic rs,
                             input int dl, input logic b8);
    pulse_t p;
    p.nib = d[7:4]; p.rs = rs; p.rise = 3;
    exp_pulse.push_back(p);
    if (b8) begin
      p.nib = d[3:0]; p.rise = 68;
      exp_pulse.push_back(p);
    end
    exp_busy.push_back((b8 ? 80 : 15) + dl);
  endtask

  task automatic send(input logic [7:0] d, input logic rs, input int dl,
                      input logic b8, input int hold);
    wait_ready(1'b1);
    bif.if_data  = d;
    bif.if_rs    = rs;
    bif.if_delay = 32'(dl);
    bif.if_8bit  = b8;
    expect_xfer(d, rs, dl, b8);
    bif.if_write = 1'b1;
    repeat (hold) @(negedge clk);
    bif.if_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bif.if_write = 1'b0;
    bif.if_data  = '0;
    bif.if_rs    = 1'b0;
    bif.if_delay = '0;
    bif.if_8bit  = 1'b0;
    #1;
    check("reset_lcd_e", lcd_e, 0);
    check("reset_lcd_rs", lcd_rs, 0);
    check("reset_lcd_d", lcd_d, 0);
    check("reset_ready", bif.if_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bif.if_ready, 1);

    // 4-bit init-style write, request held two cycles
    send(8'h30, 1'b0, 100, 1'b0, 2);

    // 8-bit data write with long delay
    send(8'h41, 1'b1, 20000, 1'b1, 1);

    // Zero delay with request held through ready: two back-to-back transfers
    wait_ready(1'b1);
    bif.if_data  = 8'h5A;
    bif.if_rs    = 1'b0;
    bif.if_delay = 32'd0;
    bif.if_8bit  = 1'b1;
    expect_xfer(8'h5A, 1'b0, 0, 1'b1);
    expect_xfer(8'h5A, 1'b0, 0, 1'b1);
    bif.if_write = 1'b1;
    wait_ready(1'b0);
    wait_ready(1'b1);
    wait_ready(1'b0);
    bif.if_write = 1'b0;

    // Inputs change while busy; latched values must win
    send(8'hA5, 1'b1, 30, 1'b1, 1);
    repeat (5) @(negedge clk);
    bif.if_data  = 8'h3C;
    bif.if_rs    = 1'b0;
    bif.if_delay = 32'd500;
    bif.if_8bit  = 1'b0;

    // Reset in the middle of the lower-nibble pulse
    send(8'h28, 1'b0, 40, 1'b1, 1);
    repeat (70) @(negedge clk);
    check("pre_reset_lcd_e", lcd_e, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_lcd_e", lcd_e, 0);
    check("abort_ready", bif.if_ready, 1);
    check("abort_lcd_d", lcd_d, 0);
    exp_pulse.delete();
    exp_busy.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_abort_ready", bif.if_ready, 1);

    send(8'h0C, 1'b0, 40, 1'b1, 1);
    send(8'h02, 1'b0, 1, 1'b0, 1);
    wait_ready(1'b1);
    repeat (3) @(negedge clk);
    check("idle_keeps_lcd_d", lcd_d, 4'h0);
    check("pending_pulses", exp_pulse.size(), 0);
    check("pending_busy", exp_busy.size(), 0);
    check("lcd_rw_high_seen", rw_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
